// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU.
// One operation in flight at a time: IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter int MULT_CYCLES = 4,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [31:0]       alu_d1,
  output logic [31:0]       alu_d2,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [31:0]       alu_s,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_cout,
  input  logic              alu_n,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam logic [FUNC_W-1:0] FN_MUL = FUNC_W'('h0E);
  localparam logic [3:0] MUL_LAST = 4'(MULT_CYCLES - 1);

  function automatic logic supported(
    input logic [FUNC_W-1:0] f
  );
    case (f)
      FUNC_W'('h04), FUNC_W'('h06),
      FUNC_W'('h07), FUNC_W'('h0E),
      FUNC_W'('h20), FUNC_W'('h21),
      FUNC_W'('h22), FUNC_W'('h23),
      FUNC_W'('h24), FUNC_W'('h25),
      FUNC_W'('h26), FUNC_W'('h28),
      FUNC_W'('h29), FUNC_W'('h2A),
      FUNC_W'('h2B), FUNC_W'('h2C),
      FUNC_W'('h2D): return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  state_e state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic own_q, own_d;
  logic prio_q, prio_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [3:0] flg_q, flg_d;
  logic err_q, err_d;

  logic idle;
  logic exec;
  logic grant1;
  logic own_rdy;

  // prio_q names the requester that wins a tie
  assign idle   = (state_q == IDLE);
  assign exec   = (state_q == EXEC);
  assign grant1 = req1_valid
                & (~req0_valid | prio_q);

  assign req0_ready = rst_n & idle
                    & req0_valid & ~grant1;
  assign req1_ready = rst_n & idle & grant1;

  assign own_rdy = own_q ? rsp1_ready
                         : rsp0_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    func_d  = func_q;
    own_d   = own_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flg_d   = flg_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          req1_ready: begin
            state_d = EXEC;
            a_d     = req1_a;
            b_d     = req1_b;
            func_d  = req1_func;
            own_d   = 1'b1;
            prio_d  = 1'b0;
            cnt_d   = (req1_func == FN_MUL)
                    ? MUL_LAST : 4'd0;
          end
          req0_ready: begin
            state_d = EXEC;
            a_d     = req0_a;
            b_d     = req0_b;
            func_d  = req0_func;
            own_d   = 1'b0;
            prio_d  = 1'b1;
            cnt_d   = (req0_func == FN_MUL)
                    ? MUL_LAST : 4'd0;
          end
          default: ;
        endcase
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (supported(func_q)) begin
            res_d = alu_s;
            flg_d = {alu_zero, alu_ovf,
                     alu_cout, alu_n};
            err_d = 1'b0;
          end else begin
            res_d = '0;
            flg_d = '0;
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (own_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      own_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      own_q   <= own_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
    end
  end

  assign busy       = ~idle;
  assign alu_d1     = exec ? a_q : '0;
  assign alu_d2     = exec ? b_q : '0;
  assign alu_func   = exec ? func_q : '0;
  assign rsp0_valid = (state_q == RESP) & ~own_q;
  assign rsp1_valid = (state_q == RESP) & own_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;
  assign rsp_err    = err_q;

endmodule
